// File: rtl/multi_button_debounce_if.sv
// Button-debouncer signal bundle: raw pins in, debounced level and event pulses out.
// The master drives the pins (board side); the slave is the debouncer.
interface multi_button_debounce_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] button_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_o;

  modport master (output button_i, input level_o, press_o, release_o, long_o);
  modport slave  (input button_i, output level_o, press_o, release_o, long_o);
endinterface

// File: rtl/multi_button_debounce.sv
// N-channel push-button debouncer: 2-flop sync, 4-state filter FSM, registered level/press/release pulses.
// Optional long-press detection is enabled by defining LONG_PRESS_EN; otherwise long_o is tied low.
module multi_button_debounce #(
  parameter int   N_CH          = 4,
  parameter int   FILTER_CYCLES = 500000,
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter int   LONG_CYCLES   = 100000000
) (
  input logic                    clk,
  input logic                    rst,
  multi_button_debounce_if.slave bus
);

  localparam int            CW       = $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILTER_IN,
    S_PRESSED,
    S_FILTER_OUT
  } state_t;

  if (FILTER_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("FILTER_CYCLES and LONG_CYCLES must both be >= 2");
  end

`ifdef LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_act;
    logic          w_cnt_last;
    logic          w_press;
    logic          w_release;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= IDLE_LEVEL;
        r_sync2 <= IDLE_LEVEL;
      end else begin
        r_sync1 <= bus.button_i[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_act      = (r_sync2 != IDLE_LEVEL);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_FILTER_OUT);
        r_press   <= w_press;
        r_release <= w_release;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_cnt_nxt   = '0;
      case (r_state)
        S_IDLE: begin
          if (w_act) w_state_nxt = S_FILTER_IN;
        end
        S_FILTER_IN: begin
          if (!w_act) begin
            w_state_nxt = S_IDLE;
          end else if (w_cnt_last) begin
            w_state_nxt = S_PRESSED;
            w_press     = 1'b1;
          end
        end
        S_PRESSED: begin
          if (!w_act) w_state_nxt = S_FILTER_OUT;
        end
        S_FILTER_OUT: begin
          if (w_act) begin
            w_state_nxt = S_PRESSED;
          end else if (w_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // The filter counter only runs while sitting in a filter state; any transition restarts it.
      if ((w_state_nxt == r_state) &&
          ((r_state == S_FILTER_IN) || (r_state == S_FILTER_OUT))) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    assign bus.level_o[g]   = r_level;
    assign bus.press_o[g]   = r_press;
    assign bus.release_o[g] = r_release;

`ifdef LONG_PRESS_EN
    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          r_long_done;

    // Hold count saturates at HOLD_LAST; r_long_done keeps it to a single pulse per press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hold      <= '0;
        r_long      <= 1'b0;
        r_long_done <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_hold      <= '0;
        r_long      <= 1'b0;
        r_long_done <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if ((r_state == S_PRESSED) && (r_hold != HOLD_LAST)) r_hold <= r_hold + 1'b1;
        if ((r_hold == HOLD_LAST) && !r_long_done) begin
          r_long      <= 1'b1;
          r_long_done <= 1'b1;
        end
      end
    end

    assign bus.long_o[g] = r_long;
`else
    assign bus.long_o[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Bench for multi_button_debounce (N_CH=2, FILTER_CYCLES=4, IDLE_LEVEL=1, LONG_CYCLES=10).
// Expected pulses are queued with their due cycle when stimulus is driven and checked against the DUT.
module tb_multi_button_debounce;

  localparam int N_CH = 2;
  localparam int LAT  = 7;  // FILTER_CYCLES + 3

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  typedef struct {
    int         cyc;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
  } ev_t;

  ev_t q[$];

  multi_button_debounce_if #(.N_CH(N_CH)) bus_if ();

  multi_button_debounce #(
    .N_CH(N_CH),
    .FILTER_CYCLES(4),
    .IDLE_LEVEL(1'b1),
    .LONG_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    ev_t e;
    e.cyc = c;
    e.prs = p;
    e.rel = r;
    e.lng = l;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    logic [5:0] obs;
    ev_t        e;
    obs = {bus_if.long_o, bus_if.release_o, bus_if.press_o};
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk($sformatf("pulse@%0d", cyc), 32'(obs), 32'({e.lng, e.rel, e.prs}));
    end else if (obs != 6'd0) begin
      chk("unexpected_pulse", 32'(obs), 32'd0);
    end
  end

  initial begin : stim
    int t;
    int r;
    bus_if.button_i = 2'b11;
    #3;
    chk("rst_level", 32'(bus_if.level_o), 0);
    chk("rst_press", 32'(bus_if.press_o), 0);
    chk("rst_release", 32'(bus_if.release_o), 0);
    chk("rst_long", 32'(bus_if.long_o), 0);
    tick(2);
    rst = 1'b0;
    tick(4);

    // Clean press and release on ch0
    t = cyc;
    bus_if.button_i[0] = 1'b0;
    push_ev(t + LAT, 2'b01, 2'b00, 2'b00);
    tick(6);
    chk("clean_level_before", 32'(bus_if.level_o), 0);
    tick(1);
    chk("clean_level_after", 32'(bus_if.level_o), 32'b01);
    bus_if.button_i[0] = 1'b1;
    push_ev(t + LAT + LAT, 2'b00, 2'b01, 2'b00);
    tick(6);
    chk("clean_level_hold", 32'(bus_if.level_o), 32'b01);
    tick(1);
    chk("clean_level_released", 32'(bus_if.level_o), 0);
    tick(3);

    // Press bounce: six 3-cycle glitches, then a real hold
    for (int i = 0; i < 6; i++) begin
      bus_if.button_i[0] = 1'b0;
      tick(3);
      bus_if.button_i[0] = 1'b1;
      tick(3);
    end
    tick(4);
    chk("bounce_level", 32'(bus_if.level_o), 0);
    t = cyc;
    bus_if.button_i[0] = 1'b0;
    push_ev(t + LAT, 2'b01, 2'b00, 2'b00);
    tick(9);
    chk("bounce_hold_level", 32'(bus_if.level_o), 32'b01);

    // Release bounce: 2 cycles high while pressed, then release for real
    bus_if.button_i[0] = 1'b1;
    tick(2);
    bus_if.button_i[0] = 1'b0;
    tick(2);
    chk("rel_bounce_level_a", 32'(bus_if.level_o), 32'b01);
    tick(2);
    chk("rel_bounce_level_b", 32'(bus_if.level_o), 32'b01);
    t = cyc;
    bus_if.button_i[0] = 1'b1;
    push_ev(t + LAT, 2'b00, 2'b01, 2'b00);
    tick(10);
    chk("rel_bounce_final", 32'(bus_if.level_o), 0);

    // Parallel press/release on both channels
    t = cyc;
    bus_if.button_i = 2'b00;
    push_ev(t + LAT, 2'b11, 2'b00, 2'b00);
    tick(8);
    chk("par_level", 32'(bus_if.level_o), 32'b11);
    bus_if.button_i = 2'b11;
    push_ev(t + 8 + LAT, 2'b00, 2'b11, 2'b00);
    tick(10);

    // Staggered by one cycle
    t = cyc;
    bus_if.button_i[0] = 1'b0;
    push_ev(t + LAT, 2'b01, 2'b00, 2'b00);
    tick(1);
    bus_if.button_i[1] = 1'b0;
    push_ev(t + 1 + LAT, 2'b10, 2'b00, 2'b00);
    tick(8);
    bus_if.button_i[0] = 1'b1;
    push_ev(t + 9 + LAT, 2'b00, 2'b01, 2'b00);
    tick(1);
    bus_if.button_i[1] = 1'b1;
    push_ev(t + 10 + LAT, 2'b00, 2'b10, 2'b00);
    tick(10);
    chk("stagger_level", 32'(bus_if.level_o), 0);

    // Reset while ch1 is pressed and ch0 is mid-filter
    t = cyc;
    bus_if.button_i[1] = 1'b0;
    push_ev(t + LAT, 2'b10, 2'b00, 2'b00);
    tick(8);
    bus_if.button_i[0] = 1'b0;
    tick(4);
    chk("pre_rst_level", 32'(bus_if.level_o), 32'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(bus_if.level_o), 0);
    chk("mid_rst_pulses", 32'({bus_if.long_o, bus_if.release_o, bus_if.press_o}), 0);
    tick(2);
    r = cyc;
    rst = 1'b0;
    push_ev(r + LAT, 2'b11, 2'b00, 2'b00);
    tick(6);
    chk("post_rst_level_early", 32'(bus_if.level_o), 0);
    tick(2);
    bus_if.button_i = 2'b11;
    push_ev(r + 8 + LAT, 2'b00, 2'b11, 2'b00);
    tick(10);

    // Long hold on ch1
    t = cyc;
    bus_if.button_i[1] = 1'b0;
    push_ev(t + LAT, 2'b10, 2'b00, 2'b00);
`ifdef LONG_PRESS_EN
    push_ev(t + LAT + 10, 2'b00, 2'b00, 2'b10);
`endif
    tick(20);
    chk("long_level", 32'(bus_if.level_o), 32'b10);
    bus_if.button_i[1] = 1'b1;
    push_ev(t + 20 + LAT, 2'b00, 2'b10, 2'b00);
    tick(12);

    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
